// File: rtl/ram64_copier_pkg.sv
// Shared definitions for the RAM64 block copier.
// Holds the FSM encoding, default widths and RAM depth.
package ram64_copier_pkg;

    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned ADDR_W_DEF = 6;
    localparam int unsigned RAM_WORDS  = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/ram64_copier_if.sv
// Port bundle between the copier (master) and an external RAM64 (slave).
interface ram64_copier_if
    import ram64_copier_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
);

    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_in;
    logic              mem_load;
    logic [DATA_W-1:0] mem_out;

    modport master (
        output mem_address,
        output mem_in,
        output mem_load,
        input  mem_out
    );

    modport slave (
        input  mem_address,
        input  mem_in,
        input  mem_load,
        output mem_out
    );

endinterface

// File: rtl/ram64_copier.sv
// Ascending word-by-word block copy inside an external RAM64.
// Each word costs one READ and one WRITE cycle; pointers wrap at the RAM depth.
module ram64_copier
    import ram64_copier_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] dst,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    ram64_copier_if.master    mem
);

    localparam int unsigned LEN_W = ADDR_W + 1;
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(RAM_WORDS);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [LEN_W-1:0]  count_q, count_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  len_eff_c;
    logic [DATA_W-1:0] data_q, data_d;

    logic              busy_d, done_d;
    logic              load_q, load_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] din_q, din_d;

    assign len_eff_c = (len > MAX_LEN) ? MAX_LEN : len;

    // Next state plus the registered output values for the state being entered
    always_comb begin
        state_d  = state_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        len_d    = len_q;
        data_d   = data_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        load_d   = 1'b0;
        addr_d   = '0;
        din_d    = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    rd_ptr_d = src;
                    wr_ptr_d = dst;
                    len_d    = len_eff_c;
                    count_d  = '0;
                    state_d  = (len_eff_c == '0) ? DONE : READ;
                end
            end
            READ: begin
                data_d  = mem.mem_out;
                state_d = WRITE;
            end
            WRITE: begin
                rd_ptr_d = rd_ptr_q + ADDR_W'(1);
                wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                count_d  = count_q + LEN_W'(1);
                state_d  = (count_d == len_q) ? DONE : READ;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // mem_out is sampled directly on the READ->WRITE edge, so din_d tracks data_d
        case (state_d)
            READ: begin
                busy_d = 1'b1;
                addr_d = rd_ptr_d;
            end
            WRITE: begin
                busy_d = 1'b1;
                load_d = 1'b1;
                addr_d = wr_ptr_d;
                din_d  = data_d;
            end
            DONE: begin
                done_d = 1'b1;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            len_q    <= '0;
            data_q   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            load_q   <= 1'b0;
            addr_q   <= '0;
            din_q    <= '0;
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            len_q    <= len_d;
            data_q   <= data_d;
            busy     <= busy_d;
            done     <= done_d;
            load_q   <= load_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
        end
    end

    // A write landing on the reset edge must not reach the RAM, hence the rst_n gate
    assign mem.mem_address = addr_q;
    assign mem.mem_in      = din_q;
    assign mem.mem_load    = load_q & rst_n;

endmodule

// File: tb/tb_ram64_copier.sv
// Bench for ram64_copier: external RAM64 model, copy-level reference trace,
// per-cycle output compare and directed plus randomized copies.
module tb_ram64_copier;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [5:0] src;
    logic [5:0] dst;
    logic [6:0] len;
    logic       busy;
    logic       done;

    always #5 clk = ~clk;

    ram64_copier_if #(.DATA_W(16), .ADDR_W(6)) bus ();

    ram64_copier #(.DATA_W(16), .ADDR_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .src   (src),
        .dst   (dst),
        .len   (len),
        .busy  (busy),
        .done  (done),
        .mem   (bus)
    );

    // External RAM64 with a bulk preload path owned by the bench
    logic [15:0] ram     [64];
    logic [15:0] pre_img [64];
    logic        pre_go;

    always @(posedge clk) begin
        if (pre_go) begin
            for (int i = 0; i < 64; i++) ram[i] <= pre_img[i];
        end else if (bus.mem_load) begin
            ram[bus.mem_address] <= bus.mem_in;
        end
    end

    assign bus.mem_out = ram[bus.mem_address];

    typedef struct {
        logic        busy;
        logic        done;
        logic        load;
        logic [5:0]  addr;
        logic [15:0] din;
    } exp_t;

    logic [15:0] shadow [64];
    exp_t        exp_q[$];
    logic [5:0]  addr_log[$];
    int          total = 0;
    int          bad = 0;
    int          mon_cyc, busy_cnt, load_cnt, done_at;
    logic        chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s @%0t: got %0h want %0h", nm, $time, act, want);
        end
    endtask

    // Every cycle: DUT outputs against the next expected trace entry (idle when empty)
    task automatic cmp_loop();
        exp_t e;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                if (exp_q.size() != 0) e = exp_q.pop_front();
                else e = '{1'b0, 1'b0, 1'b0, 6'd0, 16'h0};
                chk("busy", 32'(busy), 32'(e.busy));
                chk("done", 32'(done), 32'(e.done));
                chk("mem_load", 32'(bus.mem_load), 32'(e.load & rst_n));
                chk("mem_address", 32'(bus.mem_address), 32'(e.addr));
                chk("mem_in", 32'(bus.mem_in), 32'(e.din));
                mon_cyc++;
                if (busy) begin
                    busy_cnt++;
                    addr_log.push_back(bus.mem_address);
                end
                if (bus.mem_load) load_cnt++;
                if (done && done_at == 0) done_at = mon_cyc;
            end
        end
    endtask

    task automatic wait_idle();
        int b = 0;
        while (exp_q.size() != 0 && b < 400) begin
            @(posedge clk);
            b++;
        end
        if (b >= 400) begin
            total++;
            bad++;
            $display("FAIL wait_idle: got %0d pending want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic rand_img();
        for (int i = 0; i < 64; i++) pre_img[i] = 16'($urandom);
    endtask

    task automatic load_img();
        for (int i = 0; i < 64; i++) shadow[i] = pre_img[i];
        pre_go = 1'b1;
        @(posedge clk);
        #1 pre_go = 1'b0;
    endtask

    task automatic check_mem();
        for (int i = 0; i < 64; i++) chk($sformatf("mem[%0d]", i), 32'(ram[i]), 32'(shadow[i]));
    endtask

    // One copy: pj = cycle index of an extra start pulse (-1 none), re = reset edge after start (0 none)
    task automatic run_copy(input int s, input int d, input int l, input int pj, input int re);
        int          n, m, ntr, sa, da;
        logic [15:0] v;
        logic [15:0] tmp [64];
        exp_t        tr[$];
        wait_idle();
        @(negedge clk);
        start = 1'b1;
        src   = 6'(s);
        dst   = 6'(d);
        len   = 7'(l);
        @(posedge clk);
        n = (l > 64) ? 64 : l;
        for (int i = 0; i < 64; i++) tmp[i] = shadow[i];
        for (int i = 0; i < n; i++) begin
            sa = (s + i) % 64;
            da = (d + i) % 64;
            v  = tmp[sa];
            tr.push_back('{1'b1, 1'b0, 1'b0, 6'(sa), 16'h0});
            tr.push_back('{1'b1, 1'b0, 1'b1, 6'(da), v});
            tmp[da] = v;
        end
        tr.push_back('{1'b0, 1'b1, 1'b0, 6'd0, 16'h0});
        if (re > 0) begin
            m   = ((re - 1) / 2 < n) ? (re - 1) / 2 : n;
            ntr = re;
        end else begin
            m   = n;
            ntr = tr.size();
        end
        for (int i = 0; i < m; i++) shadow[(d + i) % 64] = shadow[(s + i) % 64];
        for (int j = 0; j < ntr; j++) exp_q.push_back(tr[j]);
        mon_cyc  = 0;
        busy_cnt = 0;
        load_cnt = 0;
        done_at  = 0;
        addr_log.delete();
        #1;
        if (re > 0) begin
            start = 1'b0;
            repeat (re - 1) @(posedge clk);
            #1 rst_n = 1'b0;
            @(posedge clk);
            #1 rst_n = 1'b1;
        end else begin
            for (int c = 0; c <= 2 * n; c++) begin
                start = (c == pj);
                src   = (c == pj) ? 6'(s + 20) : 6'($urandom);
                dst   = 6'($urandom);
                len   = 7'($urandom);
                @(posedge clk);
                #1;
            end
            start = 1'b0;
        end
        wait_idle();
    endtask

    int exp_addr [6] = '{62, 10, 63, 11, 0, 12};

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        src    = '0;
        dst    = '0;
        len    = '0;
        pre_go = 1'b0;
        fork
            cmp_loop();
        join_none

        for (int i = 0; i < 64; i++) pre_img[i] = 16'h0;
        load_img();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst mem_load", 32'(bus.mem_load), 32'd0);
        chk("rst mem_address", 32'(bus.mem_address), 32'd0);
        chk("rst mem_in", 32'(bus.mem_in), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk_en = 1'b1;

        // Basic four-word copy, then the same with a stray start mid-copy
        for (int t = 0; t < 2; t++) begin
            rand_img();
            pre_img[0] = 16'd1; pre_img[1] = 16'd3; pre_img[2] = 16'd7; pre_img[3] = 16'd15;
            load_img();
            run_copy(0, 32, 4, (t == 1) ? 2 : -1, 0);
            chk("basic done_at", 32'(done_at), 32'd9);
            chk("basic busy_cnt", 32'(busy_cnt), 32'd8);
            chk("basic mem32", 32'(ram[32]), 32'd1);
            chk("basic mem33", 32'(ram[33]), 32'd3);
            chk("basic mem34", 32'(ram[34]), 32'd7);
            chk("basic mem35", 32'(ram[35]), 32'd15);
            check_mem();
        end

        // Pointer wrap
        rand_img();
        pre_img[62] = 16'h00AA; pre_img[63] = 16'h00BB; pre_img[0] = 16'h00CC;
        load_img();
        run_copy(62, 10, 3, -1, 0);
        chk("wrap addr count", 32'(addr_log.size()), 32'd6);
        for (int i = 0; i < 6; i++)
            if (i < addr_log.size()) chk("wrap addr seq", 32'(addr_log[i]), 32'(exp_addr[i]));
        chk("wrap mem10", 32'(ram[10]), 32'h00AA);
        chk("wrap mem11", 32'(ram[11]), 32'h00BB);
        chk("wrap mem12", 32'(ram[12]), 32'h00CC);
        check_mem();

        // Zero length and clamped length
        run_copy(5, 9, 0, -1, 0);
        chk("len0 done_at", 32'(done_at), 32'd1);
        chk("len0 load_cnt", 32'(load_cnt), 32'd0);
        check_mem();
        run_copy(0, 0, 100, -1, 0);
        chk("len100 done_at", 32'(done_at), 32'd129);
        chk("len100 load_cnt", 32'(load_cnt), 32'd64);
        check_mem();

        // Overlapping ranges propagate forward
        rand_img();
        pre_img[5] = 16'h0001; pre_img[6] = 16'h0002;
        load_img();
        run_copy(5, 6, 2, -1, 0);
        chk("ovl mem6", 32'(ram[6]), 32'h0001);
        chk("ovl mem7", 32'(ram[7]), 32'h0001);
        check_mem();

        // Reset at the sixth edge after start
        rand_img();
        load_img();
        run_copy(0, 40, 8, -1, 6);
        chk("rstmid done_at", 32'(done_at), 32'd0);
        chk("rstmid mem40", 32'(ram[40]), 32'(pre_img[0]));
        chk("rstmid mem41", 32'(ram[41]), 32'(pre_img[1]));
        for (int i = 42; i < 48; i++) chk("rstmid untouched", 32'(ram[i]), 32'(pre_img[i]));
        check_mem();

        // Randomized copies, stray starts and occasional resets
        for (int t = 0; t < 30; t++) begin
            int s, d, l, n, pj, re;
            if (t % 4 == 0) begin
                rand_img();
                load_img();
            end
            s  = $urandom_range(0, 63);
            d  = $urandom_range(0, 63);
            l  = (t % 5 == 0) ? $urandom_range(0, 127) : $urandom_range(0, 12);
            n  = (l > 64) ? 64 : l;
            pj = -1;
            re = 0;
            case ($urandom_range(0, 3))
                0: pj = $urandom_range(0, 2 * n);
                1: re = $urandom_range(1, 2 * n + 1);
                default: pj = -1;
            endcase
            run_copy(s, d, l, pj, re);
            check_mem();
        end

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram64_copier.md
RAM64_COPIER -- requirements
Module: ram64_copier

Interface
REQ-001 Parameter DATA_W, default 16, word width of the attached RAM64 data path.
REQ-002 Parameter ADDR_W, default 6, address width of the attached RAM64 (64 words).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  request a block copy; sampled only in IDLE.
REQ-006 src  input  ADDR_W  first source word address.
REQ-007 dst  input  ADDR_W  first destination word address.
REQ-008 len  input  ADDR_W+1  number of words to copy, 0..64.
REQ-009 busy  output  1  high while a copy is in progress (READ or WRITE state).
REQ-010 done  output  1  one-cycle pulse when a copy completes.
REQ-011 mem_address  output  ADDR_W  address driven to the RAM64 address port.
REQ-012 mem_in  output  DATA_W  write data driven to the RAM64 in port.
REQ-013 mem_load  output  1  RAM64 load; the RAM writes mem_in at mem_address on the clk edge where it is high.
REQ-014 mem_out  input  DATA_W  RAM64 out port; combinational read of mem_address.

Function
REQ-015 The block SHALL implement the four-state FSM IDLE, READ, WRITE, DONE.
REQ-016 IDLE: start=1 latches src, dst, and effective length; next state is READ, or DONE if the effective length is 0.
REQ-017 The effective length SHALL be len clamped to 64; len 65..127 copies 64 words.
REQ-018 READ: mem_address=rd_ptr, mem_load=0; at the edge, mem_out is captured into data_q, then go to WRITE.
REQ-019 WRITE: mem_address=wr_ptr, mem_in=data_q, mem_load=1; at the edge, rd_ptr, wr_ptr, and the word count each increment by 1.
REQ-020 After WRITE, the next state is DONE if count equals the effective length, else READ.
REQ-021 rd_ptr and wr_ptr SHALL wrap modulo 64 (63+1 -> 0).
REQ-022 DONE: done=1 for exactly one cycle, then go to IDLE unconditionally.
REQ-023 Copy order SHALL be ascending. Overlapping ranges with dst inside (src, src+len) propagate already-copied data; this is the defined behaviour, not memmove.
REQ-024 Latency: for N>0, start sampled at edge k gives done high in the cycle after edge k+2N; for N=0, done is high in the cycle after edge k.
REQ-025 start while busy or in DONE SHALL be ignored; src, dst, and len changes during a copy have no effect.
REQ-026 In IDLE and DONE, mem_load=0, mem_address=0, mem_in=0.
REQ-027 busy SHALL be high exactly in READ and WRITE.

Reset
REQ-028 rst_n=0 at a clk edge SHALL force IDLE, rd_ptr=wr_ptr=count=0, data_q=0.
REQ-029 Reset SHALL force busy=0, done=0, mem_load=0, mem_address=0, mem_in=0.
REQ-030 Reset mid-copy SHALL abort the copy without a done pulse. Words written before the reset edge remain; no further writes occur. A WRITE cycle coinciding with the reset edge has its mem_load suppressed.

Structure
REQ-031 The shared package ram64_copier_pkg SHALL hold the state encoding (IDLE=0, READ=1, WRITE=2, DONE=3), DATA_W/ADDR_W defaults, and the constant RAM_WORDS=64.
REQ-032 The block SHALL have no sub-module; the RAM64 stays external and is instantiated alongside it by the parent or bench.

Verification
REQ-033 Preload RAM[0..3]=1,3,7,15; src=0, dst=32, len=4 -> RAM[32..35]=1,3,7,15; done pulses 9 cycles after the start edge; busy high for 8 cycles.
REQ-034 Wrap: RAM[62]=16'h00AA, RAM[63]=16'h00BB, RAM[0]=16'h00CC; src=62, dst=10, len=3 -> RAM[10..12]=AA,BB,CC; mem_address sequence 62,10,63,11,0,12.
REQ-035 len=0 -> done one cycle after start, mem_load never asserted, RAM unchanged; len=100 with src=0, dst=0 -> 64 words rewritten unchanged, done after 129 cycles.
REQ-036 Overlap: RAM[5]=16'h0001, RAM[6]=16'h0002; src=5, dst=6, len=2 -> RAM[6]=1, RAM[7]=1.
REQ-037 Reset mid-copy: src=0, dst=40, len=8, rst_n low at the 6th edge after start -> RAM[40..41] written, RAM[42..47] unchanged, no done, outputs idle next cycle.
REQ-038 start pulsed again while busy with different src -> ignored; the first copy completes exactly as in REQ-033.
